// File: rtl/fft_quad_combine_if.sv
// ---------------------------------------------------------------------------
// fft_quad_combine_if
// Stream bundle for the radix-4 recombination stage.
//   s_data_0..3 : lane A..D bin, {imag, real}, real in the LSBs
//   s_k         : bin index of the input beat
//   s_scale     : arithmetic right shift 0..2 applied to this beat
//   s_valid     : per-lane valid (a beat needs all four)
//   s_ready     : stage can take a beat
//   m_data_0..3 : output bins 0..3, {imag, real}
//   m_k, m_last : bin index and end-of-frame marker of the output beat
//   m_valid     : output beat valid
//   m_ready     : downstream ready
// Modport slave is the stage's view; modport master is the producer/consumer
// view that drives s_* and m_ready.
// ---------------------------------------------------------------------------
interface fft_quad_combine_if #(
   parameter int DATA_WIDTH = 32,
   parameter int K_WIDTH    = 14
);
   logic [2*DATA_WIDTH-1:0] s_data_0;
   logic [2*DATA_WIDTH-1:0] s_data_1;
   logic [2*DATA_WIDTH-1:0] s_data_2;
   logic [2*DATA_WIDTH-1:0] s_data_3;
   logic [K_WIDTH-1:0]      s_k;
   logic [1:0]              s_scale;
   logic [3:0]              s_valid;
   logic                    s_ready;
   logic [2*DATA_WIDTH-1:0] m_data_0;
   logic [2*DATA_WIDTH-1:0] m_data_1;
   logic [2*DATA_WIDTH-1:0] m_data_2;
   logic [2*DATA_WIDTH-1:0] m_data_3;
   logic [K_WIDTH-1:0]      m_k;
   logic                    m_last;
   logic                    m_valid;
   logic                    m_ready;

   modport slave (
      input  s_data_0, s_data_1, s_data_2, s_data_3, s_k, s_scale, s_valid,
      output s_ready,
      output m_data_0, m_data_1, m_data_2, m_data_3, m_k, m_last, m_valid,
      input  m_ready
   );

   modport master (
      output s_data_0, s_data_1, s_data_2, s_data_3, s_k, s_scale, s_valid,
      input  s_ready,
      input  m_data_0, m_data_1, m_data_2, m_data_3, m_k, m_last, m_valid,
      output m_ready
   );
endinterface

// File: rtl/fft_quad_combine.sv
// ---------------------------------------------------------------------------
// fft_quad_combine
// Radix-4 recombination stage: four twiddle-rotated sub-FFT bins (lanes A..D,
// same bin k) go through a 3-stage registered butterfly, per-beat scaling and
// narrowing, then into a first-word-fall-through output FIFO.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : fft_quad_combine_if.slave (input beats, output beats)
//   clear_err  : clears the sticky flags (a same-cycle set wins)
//   err_align  : sticky, s_valid was partially set
//   err_seq    : sticky, accepted s_k differed from the expected index
//   ovf        : sticky, a component was clamped (SATURATE_EN builds only)
//   frame_cnt  : number of m_last handshakes, wraps
// Build option: define SATURATE_EN to clamp out-of-range results and report
// them on ovf; otherwise results wrap and ovf is tied low.
// ---------------------------------------------------------------------------
module fft_quad_combine #(
   parameter int DATA_WIDTH = 32,
   parameter int K_WIDTH    = 14,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   fft_quad_combine_if.slave     bus,
   input  logic                  clear_err,
   output logic                  err_align,
   output logic                  err_seq,
   output logic                  ovf,
   output logic [31:0]           frame_cnt
);
   localparam int W       = DATA_WIDTH + 2;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = 8*DATA_WIDTH + K_WIDTH + 1;
   localparam logic [AW+1:0] DEPTH_L = (AW+2)'(FIFO_DEPTH);

   typedef logic signed [W-1:0] wide_t;

   function automatic wide_t sx(input logic [DATA_WIDTH-1:0] v);
      return {{2{v[DATA_WIDTH-1]}}, v};
   endfunction

`ifdef SATURATE_EN
   localparam wide_t SAT_MAX = wide_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
   localparam wide_t SAT_MIN = ~SAT_MAX;

   function automatic logic is_clamped(input wide_t t);
      return (t > SAT_MAX) || (t < SAT_MIN);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] narrow(input wide_t t);
      if (t > SAT_MAX)      return DATA_WIDTH'(SAT_MAX);
      else if (t < SAT_MIN) return DATA_WIDTH'(SAT_MIN);
      else                  return DATA_WIDTH'(t);
   endfunction
`else
   function automatic logic [DATA_WIDTH-1:0] narrow(input wide_t t);
      return DATA_WIDTH'(t);
   endfunction
`endif

   logic [2*DATA_WIDTH-1:0] lane [4];
   wide_t in_re [4], in_im [4];
   logic s_ready_int, accept;

   wide_t s1_pac_re, s1_pac_im, s1_mac_re, s1_mac_im;
   wide_t s1_pbd_re, s1_pbd_im, s1_mbd_re, s1_mbd_im;
   wide_t s2_re [4], s2_im [4], sh_re [4], sh_im [4];
   logic [2*DATA_WIDTH-1:0] s3_next [4], s3_data [4];
   logic s1_valid, s2_valid, s3_valid, s1_last, s2_last, s3_last;
   logic [K_WIDTH-1:0] s1_k, s2_k, s3_k, exp_k;
   logic [1:0] s1_scale, s2_scale;
   logic [1:0] inflight;

   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [ENTRY_W-1:0] head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic push, pop;

   assign lane[0] = bus.s_data_0;
   assign lane[1] = bus.s_data_1;
   assign lane[2] = bus.s_data_2;
   assign lane[3] = bus.s_data_3;

   // Split each lane into sign-extended real/imag so the sums cannot overflow.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         in_re[i] = sx(lane[i][DATA_WIDTH-1:0]);
         in_im[i] = sx(lane[i][2*DATA_WIDTH-1:DATA_WIDTH]);
      end
   end

   // Credit scheme: every beat already in the pipe owns a FIFO slot, so S3 can
   // always push without a stall path back through the butterfly.
   assign inflight    = {1'b0, s1_valid} + {1'b0, s2_valid} + {1'b0, s3_valid};
   assign s_ready_int = ((AW+2)'(count) + (AW+2)'(inflight)) < DEPTH_L;
   assign bus.s_ready = s_ready_int;
   assign accept      = (&bus.s_valid) && s_ready_int;

   // S1: pairwise sums/differences A+-C and B+-D shared by all four outputs.
   always_ff @(posedge clk) begin
      s1_pac_re <= in_re[0] + in_re[2];
      s1_pac_im <= in_im[0] + in_im[2];
      s1_mac_re <= in_re[0] - in_re[2];
      s1_mac_im <= in_im[0] - in_im[2];
      s1_pbd_re <= in_re[1] + in_re[3];
      s1_pbd_im <= in_im[1] + in_im[3];
      s1_mbd_re <= in_re[1] - in_re[3];
      s1_mbd_im <= in_im[1] - in_im[3];
      s1_k      <= bus.s_k;
      s1_scale  <= bus.s_scale;
      s1_last   <= &bus.s_k;
   end

   // S2: final sums; odd bins rotate (B-D) by -j (bin 1) or +j (bin 3).
   always_ff @(posedge clk) begin
      s2_re[0] <= s1_pac_re + s1_pbd_re;
      s2_im[0] <= s1_pac_im + s1_pbd_im;
      s2_re[2] <= s1_pac_re - s1_pbd_re;
      s2_im[2] <= s1_pac_im - s1_pbd_im;
      s2_re[1] <= s1_mac_re + s1_mbd_im;
      s2_im[1] <= s1_mac_im - s1_mbd_re;
      s2_re[3] <= s1_mac_re - s1_mbd_im;
      s2_im[3] <= s1_mac_im + s1_mbd_re;
      s2_k     <= s1_k;
      s2_scale <= s1_scale;
      s2_last  <= s1_last;
   end

   // S3 input: apply the beat's scale, then narrow back to DATA_WIDTH.
`ifdef SATURATE_EN
   logic clamp_any;
`endif
   always_comb begin
`ifdef SATURATE_EN
      clamp_any = 1'b0;
`endif
      for (int i = 0; i < 4; i++) begin
         sh_re[i]   = s2_re[i] >>> s2_scale;
         sh_im[i]   = s2_im[i] >>> s2_scale;
         s3_next[i] = {narrow(sh_im[i]), narrow(sh_re[i])};
`ifdef SATURATE_EN
         clamp_any  = clamp_any | is_clamped(sh_re[i]) | is_clamped(sh_im[i]);
`endif
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) s3_data[i] <= s3_next[i];
      s3_k    <= s2_k;
      s3_last <= s2_last;
   end

   // Pipeline valids, sequence tracking, sticky error flags and frame count.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         s3_valid  <= 1'b0;
         exp_k     <= '0;
         err_align <= 1'b0;
         err_seq   <= 1'b0;
         frame_cnt <= 32'd0;
      end else begin
         s1_valid <= accept;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
         if (accept) exp_k <= bus.s_k + K_WIDTH'(1);
         if (bus.s_valid != 4'h0 && bus.s_valid != 4'hF) err_align <= 1'b1;
         else if (clear_err)                              err_align <= 1'b0;
         if (accept && bus.s_k != exp_k) err_seq <= 1'b1;
         else if (clear_err)             err_seq <= 1'b0;
         if (pop && bus.m_last) frame_cnt <= frame_cnt + 32'd1;
      end
   end

`ifdef SATURATE_EN
   // Overflow flag only exists when clamping is built in.
   always_ff @(posedge clk) begin
      if (reset)                      ovf <= 1'b0;
      else if (s2_valid && clamp_any) ovf <= 1'b1;
      else if (clear_err)             ovf <= 1'b0;
   end
`else
   assign ovf = 1'b0;
`endif

   // Output FIFO: the push is guarded against full as a backstop only; the
   // credit check means a push at full only ever coincides with a pop.
   assign pop  = bus.m_valid && bus.m_ready;
   assign push = s3_valid && ((count != (AW+1)'(FIFO_DEPTH)) || pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {s3_last, s3_k, s3_data[3], s3_data[2], s3_data[1], s3_data[0]};
   end

   // First-word-fall-through read side.
   assign head         = mem[rd_ptr];
   assign bus.m_valid  = (count != '0);
   assign bus.m_data_0 = head[0*2*DATA_WIDTH +: 2*DATA_WIDTH];
   assign bus.m_data_1 = head[1*2*DATA_WIDTH +: 2*DATA_WIDTH];
   assign bus.m_data_2 = head[2*2*DATA_WIDTH +: 2*DATA_WIDTH];
   assign bus.m_data_3 = head[3*2*DATA_WIDTH +: 2*DATA_WIDTH];
   assign bus.m_k      = head[8*DATA_WIDTH +: K_WIDTH];
   assign bus.m_last   = bus.m_valid && head[ENTRY_W-1];
endmodule

// File: tb/tb_fft_quad_combine.sv
// ---------------------------------------------------------------------------
// tb_fft_quad_combine
// Directed bench for fft_quad_combine (DATA_WIDTH=32, K_WIDTH=14,
// FIFO_DEPTH=16). Each accepted beat pushes its hand-computed expected
// output onto a queue; an independent monitor pops and compares on every
// output handshake.
// ---------------------------------------------------------------------------
module tb_fft_quad_combine;
   localparam int DW = 32;
   localparam int KW = 14;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic [63:0] d3, d2, d1, d0;
      logic [KW-1:0] k;
      logic last;
   } beat_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clear_err = 1'b0;
   logic err_align, err_seq, ovf;
   logic [31:0] frame_cnt;

   int n_compared = 0;
   int n_mismatched = 0;
   beat_t exp_q[$];

   fft_quad_combine_if #(.DATA_WIDTH(DW), .K_WIDTH(KW)) bus();

   fft_quad_combine #(.DATA_WIDTH(DW), .K_WIDTH(KW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .clear_err(clear_err),
      .err_align(err_align),
      .err_seq(err_seq),
      .ovf(ovf),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Pack a complex value as {imag, real}.
   function automatic logic [63:0] cx(input int re, input int im);
      return {32'(im), 32'(re)};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Offer one beat for up to 'bound' cycles; record the expectation only if
   // the DUT actually takes it. Called and returns at posedge+1.
   task automatic applyStimulus(input logic [63:0] a, b, c, d, input logic [KW-1:0] k,
                                input logic [1:0] scale, input logic [63:0] e0, e1, e2, e3,
                                input int bound, output bit accepted);
      beat_t e;
      bus.s_data_0 = a;
      bus.s_data_1 = b;
      bus.s_data_2 = c;
      bus.s_data_3 = d;
      bus.s_k      = k;
      bus.s_scale  = scale;
      bus.s_valid  = 4'hF;
      accepted     = 1'b0;
      for (int i = 0; i < bound && !accepted; i++) begin
         if (bus.s_ready) begin
            e.d0 = e0; e.d1 = e1; e.d2 = e2; e.d3 = e3;
            e.k = k;
            e.last = (k == {KW{1'b1}});
            exp_q.push_back(e);
            accepted = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus.s_valid = 4'h0;
   endtask

   task automatic sendBeat(input logic [63:0] a, b, c, d, input logic [KW-1:0] k,
                           input logic [1:0] scale, input logic [63:0] e0, e1, e2, e3);
      bit acc;
      applyStimulus(a, b, c, d, k, scale, e0, e1, e2, e3, 20, acc);
      checkOutput("accepted", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      repeat (2) begin @(posedge clk); #1; end
      checkOutput("drain_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic doReset();
      bus.s_valid = 4'h0;
      bus.m_ready = 1'b1;
      clear_err   = 1'b0;
      reset       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic pulseClear();
      clear_err = 1'b1;
      @(posedge clk); #1;
      clear_err = 1'b0;
   endtask

   // Scoreboard monitor: any output handshake must match the queue head.
   always @(negedge clk) begin
      beat_t e;
      if (!reset && bus.m_valid && bus.m_ready) begin
         if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_beat: got m_k %0d, expected no output", bus.m_k);
         end else begin
            e = exp_q.pop_front();
            checkOutput("m_data_0", bus.m_data_0, e.d0);
            checkOutput("m_data_1", bus.m_data_1, e.d1);
            checkOutput("m_data_2", bus.m_data_2, e.d2);
            checkOutput("m_data_3", bus.m_data_3, e.d3);
            checkOutput("m_k", 64'(bus.m_k), 64'(e.k));
            checkOutput("m_last", 64'(bus.m_last), 64'(e.last));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [63:0] z, sat_exp;
      bit acc;
      int n_acc;
      z = 64'd0;
      bus.s_data_0 = z; bus.s_data_1 = z; bus.s_data_2 = z; bus.s_data_3 = z;
      bus.s_k = '0; bus.s_scale = 2'd0; bus.s_valid = 4'h0; bus.m_ready = 1'b1;

      // Reset state
      doReset();
      checkOutput("rst_m_valid", 64'(bus.m_valid), 64'd0);
      checkOutput("rst_m_last", 64'(bus.m_last), 64'd0);
      checkOutput("rst_s_ready", 64'(bus.s_ready), 64'd1);
      checkOutput("rst_err_align", 64'(err_align), 64'd0);
      checkOutput("rst_err_seq", 64'(err_seq), 64'd0);
      checkOutput("rst_ovf", 64'(ovf), 64'd0);
      checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd0);

      // Impulse on A, latency 4 cycles from accept
      applyStimulus(cx(1, 0), z, z, z, 14'd0, 2'd0, cx(1, 0), cx(1, 0), cx(1, 0), cx(1, 0), 20, acc);
      checkOutput("lat_accept", 64'(acc), 64'd1);
      checkOutput("lat_c1", 64'(bus.m_valid), 64'd0);
      @(posedge clk); #1;
      checkOutput("lat_c2", 64'(bus.m_valid), 64'd0);
      @(posedge clk); #1;
      checkOutput("lat_c3", 64'(bus.m_valid), 64'd0);
      @(posedge clk); #1;
      checkOutput("lat_c4", 64'(bus.m_valid), 64'd1);
      drain();

      // Equal lanes: only bin 0 survives
      sendBeat(cx(100, -50), cx(100, -50), cx(100, -50), cx(100, -50), 14'd1, 2'd0,
               cx(400, -200), z, z, z);
      // B = j only
      sendBeat(z, cx(0, 1), z, z, 14'd2, 2'd0, cx(0, 1), cx(1, 0), cx(0, -1), cx(-1, 0));
      drain();

      // Full-scale reals, no scaling: wrap or clamp
`ifdef SATURATE_EN
      sat_exp = 64'h0000_0000_7FFF_FFFF;
`else
      sat_exp = 64'h0000_0000_FFFF_FFFC;
`endif
      sendBeat(cx(32'h7FFFFFFF, 0), cx(32'h7FFFFFFF, 0), cx(32'h7FFFFFFF, 0), cx(32'h7FFFFFFF, 0),
               14'd3, 2'd0, sat_exp, z, z, z);
      drain();
`ifdef SATURATE_EN
      checkOutput("ovf_after_full_scale", 64'(ovf), 64'd1);
`else
      checkOutput("ovf_after_full_scale", 64'(ovf), 64'd0);
`endif
      pulseClear();
      checkOutput("ovf_cleared", 64'(ovf), 64'd0);

      // Same input with scale 2 fits exactly
      sendBeat(cx(32'h7FFFFFFF, 0), cx(32'h7FFFFFFF, 0), cx(32'h7FFFFFFF, 0), cx(32'h7FFFFFFF, 0),
               14'd4, 2'd2, 64'h0000_0000_7FFF_FFFF, z, z, z);
      // Scale 1 on A only, negative imag rounds toward -inf
      sendBeat(cx(4, -4), z, z, z, 14'd5, 2'd1, cx(2, -2), cx(2, -2), cx(2, -2), cx(2, -2));
      drain();
      checkOutput("ovf_scale2", 64'(ovf), 64'd0);
      checkOutput("err_seq_in_order", 64'(err_seq), 64'd0);
      checkOutput("err_align_clean", 64'(err_align), 64'd0);

      // Partial valid: flag set, nothing taken
      bus.s_valid = 4'b0111;
      @(posedge clk); #1;
      bus.s_valid = 4'h0;
      checkOutput("err_align_set", 64'(err_align), 64'd1);
      repeat (8) begin @(posedge clk); #1; end
      checkOutput("align_no_output", 64'(bus.m_valid), 64'd0);
      pulseClear();
      checkOutput("err_align_cleared", 64'(err_align), 64'd0);

      // Sequence gap 0,1,3
      doReset();
      sendBeat(z, z, z, z, 14'd0, 2'd0, z, z, z, z);
      sendBeat(z, z, z, z, 14'd1, 2'd0, z, z, z, z);
      checkOutput("err_seq_before_gap", 64'(err_seq), 64'd0);
      sendBeat(z, z, z, z, 14'd3, 2'd0, z, z, z, z);
      checkOutput("err_seq_gap", 64'(err_seq), 64'd1);
      drain();

      // Backpressure: 20 offered, 16 taken, then release
      doReset();
      bus.m_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 20; i++) begin
         if (n_acc == i) begin
            applyStimulus(cx(i, 0), z, z, z, KW'(i), 2'd0, cx(i, 0), cx(i, 0), cx(i, 0), cx(i, 0), 6, acc);
            if (acc) n_acc++;
         end
      end
      checkOutput("bp_accepted", 64'(n_acc), 64'd16);
      checkOutput("bp_s_ready", 64'(bus.s_ready), 64'd0);
      checkOutput("bp_hold_valid", 64'(bus.m_valid), 64'd1);
      checkOutput("bp_hold_k", 64'(bus.m_k), 64'd0);
      bus.m_ready = 1'b1;
      for (int i = n_acc; i < 20; i++)
         sendBeat(cx(i, 0), z, z, z, KW'(i), 2'd0, cx(i, 0), cx(i, 0), cx(i, 0), cx(i, 0));
      drain();

      // Full frame: m_last only on the final bin
      doReset();
      for (int k = 0; k < (1 << KW); k++)
         sendBeat(z, z, z, z, KW'(k), 2'd0, z, z, z, z);
      drain();
      checkOutput("frame_cnt", 64'(frame_cnt), 64'd1);
      checkOutput("frame_err_seq", 64'(err_seq), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
